// File: rtl/ccl_pkg.sv
// Shared types and constants for the first-pass connected-component labeler.
// Default geometry matches the 320x240 motion mask; modules override via parameters.
package ccl_pkg;

  localparam int CCL_LABEL_WIDTH = 8;
  localparam int CCL_IMG_WIDTH   = 320;
  localparam int CCL_IMG_HEIGHT  = 240;

  typedef logic [CCL_LABEL_WIDTH-1:0]         label_t;
  typedef logic [$clog2(CCL_IMG_WIDTH)-1:0]  col_t;
  typedef logic [$clog2(CCL_IMG_HEIGHT)-1:0] row_t;

  localparam label_t BG_LABEL  = {CCL_LABEL_WIDTH{1'b0}};
  localparam label_t SAT_LABEL = {CCL_LABEL_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ccl_state_e;

endpackage

// File: rtl/ccl_line_buffer.sv
// One row of provisional labels: combinational read and clocked write at the
// current column, so a read returns the label written one row earlier.
module ccl_line_buffer
  import ccl_pkg::*;
#(
  parameter int  IMG_WIDTH   = CCL_IMG_WIDTH,
  parameter int  LABEL_WIDTH = CCL_LABEL_WIDTH,
  localparam int CW          = $clog2(IMG_WIDTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [CW-1:0]          addr,
  input  logic [LABEL_WIDTH-1:0] wdata,
  output logic [LABEL_WIDTH-1:0] rdata
);

  logic [LABEL_WIDTH-1:0] mem_q [IMG_WIDTH];

  assign rdata = mem_q[addr];

  // label storage, deliberately not reset: row 0 never reads it
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/ccl_labeler.sv
// Raster-order provisional labeler with 4-connectivity (left, up); resolves the
// up neighbour through the merger and reports min/max merge pairs.
module ccl_labeler
  import ccl_pkg::*;
#(
  parameter int  LABEL_WIDTH = CCL_LABEL_WIDTH,
  parameter int  IMG_WIDTH   = CCL_IMG_WIDTH,
  parameter int  IMG_HEIGHT  = CCL_IMG_HEIGHT,
  localparam int CW          = $clog2(IMG_WIDTH),
  localparam int RW          = $clog2(IMG_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  input  logic                   pix_fg,
  output logic                   resolve_valid,
  output logic [LABEL_WIDTH-1:0] resolve_label,
  input  logic [LABEL_WIDTH-1:0] resolved_label,
  output logic                   merge_valid,
  output logic [LABEL_WIDTH-1:0] merge_a,
  output logic [LABEL_WIDTH-1:0] merge_b,
  output logic                   label_valid,
  output logic [LABEL_WIDTH-1:0] label_out,
  output logic [CW-1:0]          label_col,
  output logic [RW-1:0]          label_row,
  output logic                   frame_done,
  output logic [LABEL_WIDTH-1:0] label_count,
  output logic                   overflow
);

  localparam int NW = LABEL_WIDTH + 1;
  typedef logic [LABEL_WIDTH-1:0] lbl_t;
  typedef logic [NW-1:0]          cnt_t;

  localparam lbl_t            BG       = lbl_t'(BG_LABEL);
  localparam lbl_t            SAT      = {LABEL_WIDTH{1'b1}};
  localparam cnt_t            SAT_CNT  = {1'b0, SAT};
  localparam logic [CW-1:0]   COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_HEIGHT - 1);

  ccl_state_e    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  lbl_t          left_q, left_d;
  cnt_t          next_label_q, next_label_d;
  logic          overflow_q, overflow_d;
  logic          label_valid_q, label_valid_d;
  lbl_t          label_out_q, label_out_d;
  logic [CW-1:0] label_col_q, label_col_d;
  logic [RW-1:0] label_row_q, label_row_d;
  logic          frame_done_q, frame_done_d;
  logic          merge_valid_q, merge_valid_d;
  lbl_t          merge_a_q, merge_a_d;
  lbl_t          merge_b_q, merge_b_d;
  lbl_t          label_count_q, label_count_d;

  logic          accept;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  cnt_t          cur_next;
  logic          cur_ovf;
  lbl_t          lb_rdata;
  lbl_t          up_raw;
  lbl_t          up;
  lbl_t          left;
  lbl_t          chosen;
  cnt_t          alloc_next;
  logic          alloc_ovf;
  logic          do_merge;
  lbl_t          m_lo;
  lbl_t          m_hi;
  logic          lb_we;

  ccl_line_buffer #(
    .IMG_WIDTH  (IMG_WIDTH),
    .LABEL_WIDTH(LABEL_WIDTH)
  ) u_line_buffer (
    .clk  (clk),
    .we   (lb_we),
    .addr (cur_col),
    .wdata(chosen),
    .rdata(lb_rdata)
  );

  // A start-of-frame pixel is processed as (0,0) of a fresh frame, even mid-frame.
  always_comb begin
    accept        = pix_valid & (pix_sof | (state_q == RUN));
    cur_col       = pix_sof ? '0 : col_q;
    cur_row       = pix_sof ? '0 : row_q;
    cur_next      = pix_sof ? cnt_t'(1) : next_label_q;
    cur_ovf       = pix_sof ? 1'b0 : overflow_q;
    up_raw        = (cur_row != '0) ? lb_rdata : BG;
    resolve_valid = accept & pix_fg & (up_raw != BG);
    resolve_label = up_raw;
    up            = resolve_valid ? resolved_label : BG;
    left          = (cur_col != '0) ? left_q : BG;
  end

  // SAT is handed out once normally; later allocations reuse it and flag overflow.
  always_comb begin
    chosen     = BG;
    alloc_next = cur_next;
    alloc_ovf  = cur_ovf;
    do_merge   = 1'b0;
    m_lo       = BG;
    m_hi       = BG;
    if (pix_fg) begin
      if ((up == BG) && (left == BG)) begin
        if (cur_next > SAT_CNT) begin
          chosen    = SAT;
          alloc_ovf = 1'b1;
        end else begin
          chosen     = cur_next[LABEL_WIDTH-1:0];
          alloc_next = cur_next + cnt_t'(1);
        end
      end else if (up == BG) begin
        chosen = left;
      end else if ((left == BG) || (up == left)) begin
        chosen = up;
      end else begin
        do_merge = 1'b1;
        m_lo     = (up < left) ? up : left;
        m_hi     = (up < left) ? left : up;
        chosen   = m_lo;
      end
    end else begin
      chosen = BG;
    end
  end

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    left_d        = left_q;
    next_label_d  = next_label_q;
    overflow_d    = overflow_q;
    label_valid_d = 1'b0;
    label_out_d   = label_out_q;
    label_col_d   = label_col_q;
    label_row_d   = label_row_q;
    frame_done_d  = 1'b0;
    merge_valid_d = 1'b0;
    merge_a_d     = merge_a_q;
    merge_b_d     = merge_b_q;
    label_count_d = label_count_q;
    lb_we         = 1'b0;
    if (accept) begin
      lb_we         = 1'b1;
      state_d       = RUN;
      left_d        = chosen;
      next_label_d  = alloc_next;
      overflow_d    = alloc_ovf;
      label_valid_d = 1'b1;
      label_out_d   = chosen;
      label_col_d   = cur_col;
      label_row_d   = cur_row;
      label_count_d = (alloc_next > SAT_CNT) ? SAT : lbl_t'(alloc_next - cnt_t'(1));
      merge_valid_d = do_merge;
      merge_a_d     = do_merge ? m_lo : merge_a_q;
      merge_b_d     = do_merge ? m_hi : merge_b_q;
      if (cur_col == COL_LAST) begin
        col_d = '0;
        if (cur_row == ROW_LAST) begin
          row_d        = '0;
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          row_d = cur_row + RW'(1);
        end
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end else begin
      state_d = state_q;
    end
  end

  // state and output registers; reset also drops any pending merge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      left_q        <= '0;
      next_label_q  <= cnt_t'(1);
      overflow_q    <= 1'b0;
      label_valid_q <= 1'b0;
      label_out_q   <= '0;
      label_col_q   <= '0;
      label_row_q   <= '0;
      frame_done_q  <= 1'b0;
      merge_valid_q <= 1'b0;
      merge_a_q     <= '0;
      merge_b_q     <= '0;
      label_count_q <= '0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      left_q        <= left_d;
      next_label_q  <= next_label_d;
      overflow_q    <= overflow_d;
      label_valid_q <= label_valid_d;
      label_out_q   <= label_out_d;
      label_col_q   <= label_col_d;
      label_row_q   <= label_row_d;
      frame_done_q  <= frame_done_d;
      merge_valid_q <= merge_valid_d;
      merge_a_q     <= merge_a_d;
      merge_b_q     <= merge_b_d;
      label_count_q <= label_count_d;
    end
  end

  assign merge_valid = merge_valid_q;
  assign merge_a     = merge_a_q;
  assign merge_b     = merge_b_q;
  assign label_valid = label_valid_q;
  assign label_out   = label_out_q;
  assign label_col   = label_col_q;
  assign label_row   = label_row_q;
  assign frame_done  = frame_done_q;
  assign label_count = label_count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ccl_labeler.sv
// Scoreboard bench for ccl_labeler on a 4x4 image with 3-bit labels; the bench
// also plays the role of the label merger (flattened root table).
module tb_ccl_labeler;

  localparam int LW  = 3;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int CW  = 2;
  localparam int RW  = 2;
  localparam int NL  = 1 << LW;
  localparam int SAT = NL - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_valid;
  logic          pix_sof;
  logic          pix_fg;
  logic          resolve_valid;
  logic [LW-1:0] resolve_label;
  logic [LW-1:0] resolved_label;
  logic          merge_valid;
  logic [LW-1:0] merge_a;
  logic [LW-1:0] merge_b;
  logic          label_valid;
  logic [LW-1:0] label_out;
  logic [CW-1:0] label_col;
  logic [RW-1:0] label_row;
  logic          frame_done;
  logic [LW-1:0] label_count;
  logic          overflow;

  always #5 clk = ~clk;

  ccl_labeler #(.LABEL_WIDTH(LW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_fg(pix_fg),
    .resolve_valid(resolve_valid), .resolve_label(resolve_label),
    .resolved_label(resolved_label), .merge_valid(merge_valid), .merge_a(merge_a),
    .merge_b(merge_b), .label_valid(label_valid), .label_out(label_out),
    .label_col(label_col), .label_row(label_row), .frame_done(frame_done),
    .label_count(label_count), .overflow(overflow)
  );

  // Each entry holds the root of its class directly; the smaller root survives.
  typedef logic [NL-1:0][LW-1:0] tbl_t;

  function automatic tbl_t tbl_clear();
    tbl_t t;
    for (int i = 0; i < NL; i++) t[i] = LW'(i);
    return t;
  endfunction

  function automatic tbl_t tbl_union(input tbl_t t_in, input int a, input int b);
    tbl_t t;
    int ra, rb, lo, hi;
    t  = t_in;
    ra = int'(t[a]);
    rb = int'(t[b]);
    lo = (ra < rb) ? ra : rb;
    hi = (ra < rb) ? rb : ra;
    for (int i = 0; i < NL; i++) if (int'(t[i]) == hi) t[i] = LW'(lo);
    return t;
  endfunction

  tbl_t mg_tbl;
  always @(posedge clk) begin
    if (!rst || frame_done) mg_tbl <= tbl_clear();
    else if (merge_valid) mg_tbl <= tbl_union(mg_tbl, int'(merge_a), int'(merge_b));
  end
  assign resolved_label = mg_tbl[resolve_label];

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int cyc; bit zero; bit lv; bit fd; bit mv; bit ovf;
    int lab; int col; int row; int cnt; int a; int b;
  } exp_t;
  typedef struct { int cyc; bit rv; int rl; } rexp_t;

  exp_t  oq[$];
  rexp_t rq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc_n);
    end
  endtask

  // monitor: compares whatever the DUT shows against the queued expectations
  always @(negedge clk) begin
    rexp_t r;
    exp_t  e;
    if (rq.size() > 0 && rq[0].cyc == cyc_n) begin
      r = rq.pop_front();
      chk("resolve_valid", int'(resolve_valid), int'(r.rv));
      if (r.rv) chk("resolve_label", int'(resolve_label), r.rl);
    end
    if (oq.size() > 0 && oq[0].cyc == cyc_n) begin
      e = oq.pop_front();
      chk("label_valid", int'(label_valid), int'(e.lv));
      chk("merge_valid", int'(merge_valid), int'(e.mv));
      chk("frame_done", int'(frame_done), int'(e.fd));
      chk("overflow", int'(overflow), int'(e.ovf));
      if (e.lv) begin
        chk("label_out", int'(label_out), e.lab);
        chk("label_col", int'(label_col), e.col);
        chk("label_row", int'(label_row), e.row);
        chk("label_count", int'(label_count), e.cnt);
        if (e.mv) begin
          chk("merge_a", int'(merge_a), e.a);
          chk("merge_b", int'(merge_b), e.b);
        end
      end
      if (e.zero) begin
        chk("rst_label_out", int'(label_out), 0);
        chk("rst_label_col", int'(label_col), 0);
        chk("rst_label_row", int'(label_row), 0);
        chk("rst_label_count", int'(label_count), 0);
        chk("rst_merge_ab", int'(merge_a) + int'(merge_b), 0);
        chk("rst_resolve_valid", int'(resolve_valid), 0);
      end
    end
  end

  // reference model state: frame position, labels of the previous row, merger mirror
  bit   m_run;
  int   m_col, m_row, m_left, m_next;
  bit   m_ovf;
  int   m_lb [W];
  tbl_t m_tbl;
  exp_t p_out, c_out;
  bit   p_rst;

  task automatic step(input bit v, input bit s, input bit f, input bit r);
    exp_t  e;
    rexp_t re;
    int    cc, cr, upraw, up, lf, lab;
    @(posedge clk);
    #1;
    rst = r; pix_valid = v; pix_sof = s; pix_fg = f;
    if (!p_rst || p_out.fd) m_tbl = tbl_clear();
    else if (p_out.mv) m_tbl = tbl_union(m_tbl, p_out.a, p_out.b);
    p_out = c_out;
    p_rst = r;
    e = '{default: 0};
    re = '{default: 0};
    if (!r) begin
      m_run = 1'b0; m_col = 0; m_row = 0; m_left = 0; m_next = 1; m_ovf = 1'b0;
      e.zero = 1'b1;
    end else if (v && (s || m_run)) begin
      if (s) begin m_col = 0; m_row = 0; m_next = 1; m_ovf = 1'b0; end
      m_run = 1'b1;
      cc = m_col; cr = m_row;
      upraw = (cr > 0) ? m_lb[cc] : 0;
      up = 0;
      if (f && upraw != 0) begin
        re.rv = 1'b1; re.rl = upraw;
        up = int'(m_tbl[upraw]);
      end
      lf = (cc == 0) ? 0 : m_left;
      if (!f) lab = 0;
      else if (up == 0 && lf == 0) begin
        if (m_next <= SAT) begin lab = m_next; m_next++; end
        else begin lab = SAT; m_ovf = 1'b1; end
      end
      else if (up == 0) lab = lf;
      else if (lf == 0) lab = up;
      else begin
        lab = (up < lf) ? up : lf;
        if (up != lf) begin e.mv = 1'b1; e.a = lab; e.b = (up < lf) ? lf : up; end
      end
      m_lb[cc] = lab;
      m_left = lab;
      e.lv = 1'b1; e.lab = lab; e.col = cc; e.row = cr;
      e.cnt = (m_next - 1 > SAT) ? SAT : m_next - 1;
      e.fd = (cc == W - 1) && (cr == H - 1);
      if (cc == W - 1) begin
        m_col = 0;
        if (cr == H - 1) begin m_row = 0; m_run = 1'b0; end
        else m_row++;
      end else m_col++;
    end
    e.ovf = m_ovf;
    e.cyc = cyc_n + 1;
    re.cyc = cyc_n;
    oq.push_back(e);
    rq.push_back(re);
    c_out = e;
  endtask

  // mask bit index = row*W + col; first n pixels, the first carrying pix_sof
  task automatic partial(input logic [15:0] mask, input int n, input int gap_pct);
    for (int p = 0; p < n; p++) begin
      while (int'($urandom_range(99, 0)) < gap_pct) step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, p == 0, mask[p], 1'b1);
    end
  endtask

  task automatic frame(input logic [15:0] mask, input int gap_pct);
    partial(mask, W * H, gap_pct);
  endtask

  initial begin
    logic [15:0] mk;
    rst = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_fg = 1'b0;
    m_run = 1'b0; m_col = 0; m_row = 0; m_left = 0; m_next = 1; m_ovf = 1'b0;
    for (int i = 0; i < W; i++) m_lb[i] = 0;
    m_tbl = tbl_clear();
    p_out = '{default: 0};
    c_out = '{default: 0};
    p_rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);              // IDLE, no sof: ignored
    frame(16'h0020, 0);                       // single pixel at (1,1)
    frame(16'h000F, 0);                       // row 0 solid
    frame(16'h0755, 0);                       // U shape, merge 1<-2 at (2,2)
    frame(16'hA5A5, 0);                       // 8 isolated pixels: saturation
    partial(16'h0005, 9, 0);                  // abort at (2,1)
    frame(16'h0031, 0);
    partial(16'hFFFF, 6, 0);                  // reset mid-frame
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1);
    frame(16'h9669, 10);
    for (int k = 0; k < 80; k++) begin
      mk = 16'($urandom);
      if ($urandom_range(1, 0) == 1) mk = mk | 16'($urandom);
      if ($urandom_range(9, 0) == 0) partial(mk, int'($urandom_range(15, 2)), 15);
      if ($urandom_range(19, 0) == 0) begin
        partial(mk, int'($urandom_range(15, 2)), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      frame(mk, 20);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("queues_drained", oq.size() + rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
